// File: rtl/ram_client_port.sv
// ram_client_port
// Low-priority initiator for port 2 of the two-port priority RAM encoder.
// Takes single-word read/write requests on a valid/ready interface, drives
// them onto the encoder's CE/WE/address/data pins, yields and retries while
// port 1 owns the RAM, and returns read data on a held response interface.
//
// Ports:
//   clk_input, rst_n_input          clock, synchronous active-low reset
//   req_valid/ready, req_we,        request channel (single word)
//   req_address, req_wdata
//   rsp_valid/ready, rsp_data       read response channel (held until taken)
//   CE/WE/address/data_inout        encoder port-2 bus
//   is_RAM_available_input          1 = port 2 currently granted
//   starved_output                  access waited STARVE_LIMIT+ cycles
//
// state   | meaning
// IDLE    | ready for a request, bus released
// ACCESS  | CE asserted, waiting for grant / read latency window
// RESPOND | read data held on rsp_data_output until accepted
module ram_client_port #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 16,
    parameter int READ_LATENCY  = 1,
    parameter int STARVE_LIMIT  = 255
) (
    input  logic                     clk_input,
    input  logic                     rst_n_input,
    input  logic                     req_valid_input,
    output logic                     req_ready_output,
    input  logic                     req_we_input,
    input  logic [ADDRESS_WIDTH-1:0] req_address_input,
    input  logic [DATA_WIDTH-1:0]    req_wdata_input,
    output logic                     rsp_valid_output,
    input  logic                     rsp_ready_input,
    output logic [DATA_WIDTH-1:0]    rsp_data_output,
    output logic                     CE_output,
    output logic                     WE_output,
    output logic [ADDRESS_WIDTH-1:0] address_output,
    inout  wire  [DATA_WIDTH-1:0]    data_inout,
    input  logic                     is_RAM_available_input,
    output logic                     starved_output
);

    localparam int GRANT_W = $clog2(READ_LATENCY) + 1;
    localparam int STALL_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [GRANT_W-1:0] GRANT_LAST = GRANT_W'(READ_LATENCY - 1);
    localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

    state_t                   state, state_next;
    logic                     we_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    rsp_data_q;
    logic [GRANT_W-1:0]       grant_cnt, grant_next;
    logic [STALL_W-1:0]       stall_cnt, stall_next;
    logic                     starved_q;
    logic                     accept;
    logic                     capture;
    logic                     drive_bus;

    assign data_inout      = drive_bus ? wdata_q : {DATA_WIDTH{1'bz}};
    assign address_output  = addr_q;
    assign rsp_data_output = rsp_data_q;
    assign starved_output  = starved_q;

    always_comb begin
        state_next       = state;
        grant_next       = grant_cnt;
        stall_next       = stall_cnt;
        accept           = 1'b0;
        capture          = 1'b0;
        // ready is masked by reset so nothing is accepted while reset is held
        req_ready_output = (state == IDLE) && rst_n_input;
        rsp_valid_output = (state == RESPOND);
        CE_output        = (state == ACCESS);
        WE_output        = (state == ACCESS) && we_q;
        drive_bus        = (state == ACCESS) && we_q;

        case (state)
            IDLE: begin
                grant_next = '0;
                if (req_valid_input && req_ready_output) begin
                    accept     = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (is_RAM_available_input) begin
                    if (we_q) begin
                        state_next = IDLE;
                    end else if (grant_cnt == GRANT_LAST) begin
                        capture    = 1'b1;
                        grant_next = '0;
                        state_next = RESPOND;
                    end else begin
                        grant_next = grant_cnt + GRANT_W'(1);
                    end
                end else begin
                    // preemption restarts the whole read latency window
                    grant_next = '0;
                    if (stall_cnt != STALL_MAX) begin
                        stall_next = stall_cnt + STALL_W'(1);
                    end
                end
            end
            RESPOND: begin
                if (rsp_ready_input) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_next == IDLE) begin
            stall_next = '0;
        end
    end

    always_ff @(posedge clk_input) begin
        if (!rst_n_input) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            grant_cnt  <= '0;
            stall_cnt  <= '0;
            starved_q  <= 1'b0;
        end else begin
            state     <= state_next;
            grant_cnt <= grant_next;
            stall_cnt <= stall_next;
            starved_q <= (stall_next >= STALL_MAX);
            if (accept) begin
                we_q    <= req_we_input;
                addr_q  <= req_address_input;
                wdata_q <= req_wdata_input;
            end
            if (capture) begin
                rsp_data_q <= data_inout;
            end
        end
    end

endmodule

// File: tb/tb_ram_client_port.sv
module tb_ram_client_port;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int RL = 2;
    localparam int SL = 3;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_address;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          ce;
    logic          we;
    logic [AW-1:0] address;
    wire  [DW-1:0] data_bus;
    logic          avail;
    logic          starved;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] exp_mem [256];
    logic [DW-1:0] ram_xor;
    logic [DW-1:0] sb_q [$];

    int n_cmp;
    int n_err;

    ram_client_port #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .READ_LATENCY(RL), .STARVE_LIMIT(SL)
    ) dut (
        .clk_input(clk),
        .rst_n_input(rst_n),
        .req_valid_input(req_valid),
        .req_ready_output(req_ready),
        .req_we_input(req_we),
        .req_address_input(req_address),
        .req_wdata_input(req_wdata),
        .rsp_valid_output(rsp_valid),
        .rsp_ready_input(rsp_ready),
        .rsp_data_output(rsp_data),
        .CE_output(ce),
        .WE_output(we),
        .address_output(address),
        .data_inout(data_bus),
        .is_RAM_available_input(avail),
        .starved_output(starved)
    );

    // RAM model on the far side of the encoder: drives read data while the
    // client holds CE with WE low; ram_xor corrupts cycles that must not be captured
    assign data_bus = (ce && !we) ? (mem[address[7:0]] ^ ram_xor) : {DW{1'bz}};

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
            mem[8'h20] <= 8'h3C;
        end else if (ce && we && avail) begin
            mem[address[7:0]] <= data_bus;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_pop_check(input string name, output logic [DW-1:0] exp_d);
        exp_d = '0;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: response with empty scoreboard, got %0h", name, rsp_data);
        end else begin
            exp_d = sb_q.pop_front();
            check(name, 32'(rsp_data), 32'(exp_d));
        end
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [15:0]   avail_pat;   // bit k-1 = grant in ACCESS cycle k
        int            exp_lat;     // cycle after accept where ready (wr) / rsp_valid (rd) appears
        int            exp_starve_k;// first cycle starved is seen, 0 = never
        int            rsp_wait;    // cycles of rsp_ready=0 backpressure
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input int idx, input vec_t v);
        int done_k, starve_k, ce_cnt, addr_bad, we_bad, bus_bad, rdy_bad, hold_bad;
        logic [DW-1:0] exp_d;
        done_k = 0; starve_k = 0; ce_cnt = 0;
        addr_bad = 0; we_bad = 0; bus_bad = 0; rdy_bad = 0; hold_bad = 0;
        @(negedge clk);
        check($sformatf("v%0d_idle_ready", idx), 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_we      = v.we;
        req_address = v.addr;
        req_wdata   = v.wdata;
        avail       = 1'b1;
        if (v.we) exp_mem[v.addr[7:0]] = v.wdata;
        else      sb_q.push_back(exp_mem[v.addr[7:0]]);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            avail   = (k > 16) ? 1'b1 : v.avail_pat[k-1];
            ram_xor = (!v.we && k != v.exp_lat - 1) ? (8'h5A ^ 8'(k)) : 8'h00;
            if (starved && starve_k == 0) starve_k = k;
            if (v.we ? req_ready : rsp_valid) begin
                done_k = k;
                break;
            end
            if (ce) begin
                ce_cnt++;
                if (address != v.addr) addr_bad++;
                if (we != v.we) we_bad++;
                if (v.we && data_bus !== v.wdata) bus_bad++;
                if (req_ready) rdy_bad++;
            end
        end
        ram_xor = 8'h00;
        avail   = 1'b1;
        check($sformatf("v%0d_latency", idx), 32'(done_k), 32'(v.exp_lat));
        check($sformatf("v%0d_ce_cycles", idx), 32'(ce_cnt), 32'(v.exp_lat - 1));
        check($sformatf("v%0d_ce_after", idx), 32'(ce), 32'd0);
        check($sformatf("v%0d_addr", idx), 32'(addr_bad), 32'd0);
        check($sformatf("v%0d_we", idx), 32'(we_bad), 32'd0);
        check($sformatf("v%0d_wbus", idx), 32'(bus_bad), 32'd0);
        check($sformatf("v%0d_ready_in_access", idx), 32'(rdy_bad), 32'd0);
        check($sformatf("v%0d_starve_cycle", idx), 32'(starve_k), 32'(v.exp_starve_k));
        if (!v.we) begin
            sb_pop_check($sformatf("v%0d_rdata", idx), exp_d);
            rsp_ready = (v.rsp_wait == 0);
            for (int w = 0; w < v.rsp_wait; w++) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_data !== exp_d || req_ready || ce) hold_bad++;
                if (w == v.rsp_wait - 1) rsp_ready = 1'b1;
            end
            check($sformatf("v%0d_rsp_hold", idx), 32'(hold_bad), 32'd0);
            @(negedge clk);
            rsp_ready = 1'b0;
            check($sformatf("v%0d_rsp_done", idx), 32'(rsp_valid), 32'd0);
            check($sformatf("v%0d_ready_back", idx), 32'(req_ready), 32'd1);
        end
        @(negedge clk);
        check($sformatf("v%0d_starve_clear", idx), 32'(starved), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] exp_d;
        int            stray;
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_address = '0; req_wdata = '0;
        rsp_ready = 1'b0; avail = 1'b1; ram_xor = 8'h00;
        for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i * 7 + 3);
        exp_mem[8'h20] = 8'h3C;

        //        we    addr      wdata  avail_pat  lat starve wait
        vecs[0] = '{1'b1, 16'h0010, 8'hA5, 16'hFFFF, 2, 0, 0};
        vecs[1] = '{1'b0, 16'h0020, 8'h00, 16'hFFFF, 3, 0, 0};
        vecs[2] = '{1'b0, 16'h0010, 8'h00, 16'hFFFD, 5, 0, 0};   // 1,0,1,1
        vecs[3] = '{1'b1, 16'h1234, 8'h5C, 16'hFFE0, 7, 4, 0};   // 5 stalls
        vecs[4] = '{1'b0, 16'h1234, 8'h00, 16'hFFFF, 3, 0, 4};   // backpressure
        vecs[5] = '{1'b0, 16'h0020, 8'h00, 16'hFFF8, 6, 4, 1};   // 3 stalls
        vecs[6] = '{1'b1, 16'h00AB, 8'h3E, 16'hFFFC, 4, 0, 0};
        vecs[7] = '{1'b0, 16'h00AB, 8'h00, 16'hFFFA, 6, 0, 2};   // 0,1,0,1,1

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_ce", 32'(ce), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_address", 32'(address), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_starved", 32'(starved), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // minimum turnaround: read issued in the first IDLE cycle after a write
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_address = 16'h0030; req_wdata = 8'h77;
        exp_mem[8'h30] = 8'h77;
        @(negedge clk);
        req_valid = 1'b0;
        check("ta_wr_ce", 32'({ce, we}), 32'h3);
        check("ta_wr_bus", 32'(data_bus), 32'h77);
        @(negedge clk);
        check("ta_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b0; req_address = 16'h0030;
        sb_q.push_back(exp_mem[8'h30]);
        @(negedge clk);
        req_valid = 1'b0;
        ram_xor   = 8'h0F;
        check("ta_rd_ce1", 32'({ce, we}), 32'h2);
        @(negedge clk);
        ram_xor = 8'h00;
        check("ta_rd_ce2", 32'({ce, we}), 32'h2);
        @(negedge clk);
        check("ta_rsp_valid", 32'(rsp_valid), 32'd1);
        sb_pop_check("ta_rdata", exp_d);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("ta_rsp_one_cycle", 32'(rsp_valid), 32'd0);

        // reset during the first ACCESS cycle of a read
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_address = 16'h0040;
        @(negedge clk);
        req_valid = 1'b0;
        check("rmid_ce", 32'(ce), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rmid_ce_drop", 32'(ce), 32'd0);
        check("rmid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rmid_ready_in_rst", 32'(req_ready), 32'd0);
        check("rmid_address", 32'(address), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rmid_ready", 32'(req_ready), 32'd1);
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || ce) stray++;
        end
        check("rmid_no_stale", 32'(stray), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_client_port.md
# ram_client_port

Low-priority client initiator for the two-port priority RAM encoder. It accepts single-word read and write requests on a valid/ready interface and drives them onto the encoder's port-2 bus (CE/WE/address/bidirectional data). When port 1 takes the RAM, the block yields and retries. Read data is returned on a held response interface. It sits between a secondary pipeline stage (for example, a table loader or debug reader) and the encoder's port-2 pins.

## Interface
- DATA_WIDTH, 8, RAM word width
- ADDRESS_WIDTH, 16, RAM address width
- READ_LATENCY, 1, consecutive granted cycles CE must be held before read data is sampled (≥1)
- STARVE_LIMIT, 255, non-granted cycles in one access before `starved_output` asserts (≥1)

Ports:
- clk_input  in  1  clock; all state updates on rising edge
- rst_n_input  in  1  synchronous, active-low reset
- req_valid_input  in  1  request present
- req_ready_output  out  1  block can accept a request
- req_we_input  in  1  1 = write, 0 = read
- req_address_input  in  ADDRESS_WIDTH  request address
- req_wdata_input  in  DATA_WIDTH  write data
- rsp_valid_output  out  1  read data valid (held until accepted)
- rsp_ready_input  in  1  consumer accepts response
- rsp_data_output  out  DATA_WIDTH  read data
- CE_output  out  1  to encoder CE2
- WE_output  out  1  to encoder WE2
- address_output  out  ADDRESS_WIDTH  to encoder address2
- data_inout  inout  DATA_WIDTH  to encoder data2; driven only during a write access, otherwise Z
- is_RAM_available_input  in  1  from encoder; 1 = port 2 currently granted
- starved_output  out  1  current access exceeded STARVE_LIMIT non-granted cycles

## Operation
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE:
  - `req_ready_output`=1.
  - On `req_valid_input && req_ready_output`, latch we/address/wdata, clear the grant counter and stall counter, and go to ACCESS.
- ACCESS:
  - `CE_output`=1, `WE_output`=latched we, `address_output`=latched address.
  - `data_inout` is driven with latched wdata only if we=1.
  - `req_ready_output`=0.
- Write in ACCESS:
  - The first cycle with `is_RAM_available_input`=1 commits the write.
  - Go to IDLE. A write produces no response.
- Read in ACCESS:
  - The grant counter (width clog2(READ_LATENCY)+1) increments on each available cycle.
  - It resets to 0 on any unavailable cycle (preemption aborts and restarts the latency window).
  - When the counter equals READ_LATENCY-1 and available=1, capture `data_inout` into `rsp_data_output` at that edge and go to RESPOND.
- Stall counter:
  - Saturating; increments on each ACCESS cycle with available=0.
  - `starved_output` = (stall counter ≥ STARVE_LIMIT), registered.
  - Cleared on entering ACCESS from IDLE and in IDLE.
- RESPOND:
  - `rsp_valid_output`=1 and `rsp_data_output` stable; CE/WE=0; `req_ready_output`=0.
  - On `rsp_ready_input`, go to IDLE next cycle.
- Outside ACCESS: `CE_output`=0, `WE_output`=0, `data_inout`=Z, and `address_output` holds its last value.

## Timing
- Reset (rst_n_input=0 at an edge):
  - State goes to IDLE.
  - `CE_output`=0, `WE_output`=0, `address_output`=0, `data_inout`=Z.
  - `rsp_valid_output`=0, `rsp_data_output`=0, `starved_output`=0.
  - `req_ready_output`=0 while reset is asserted, 1 in the first cycle after release.
- Reset mid-ACCESS or mid-RESPOND: the access is aborted, CE drops at that edge, and no response is issued.
- Request acceptance to CE high: 1 cycle. CE asserts in the cycle after the accept edge.
- Uncontended write: accept edge, then 1 ACCESS cycle; back in IDLE 2 cycles after accept.
- Uncontended read: READ_LATENCY ACCESS cycles, then RESPOND. `rsp_valid_output` rises READ_LATENCY+1 cycles after the accept edge.
- Minimum turnaround: a new request can be accepted the cycle after a write commits, or the cycle after the response handshake.
- Preemption in the last latency cycle: no capture; the full READ_LATENCY window restarts.
- Simultaneous `rsp_ready_input` in the first RESPOND cycle: handshake completes; rsp_valid is high for exactly 1 cycle.
- The block never drives `data_inout` while WE=0, and never while in IDLE or RESPOND.

## Test plan
- Uncontended write: write addr 0x0010, data 0xA5, available=1 → CE=WE=1 for exactly 1 cycle with data_inout=0xA5; req_ready returns 2 cycles after accept.
- Uncontended read, READ_LATENCY=2: RAM model returns 0x3C for addr 0x0020 → CE=1 for 2 cycles with data_inout=Z from the block; rsp_valid=1 with rsp_data=0x3C 3 cycles after accept.
- Preempted read, READ_LATENCY=2: available pattern 1,0,1,1 → CE held 4 cycles; data is captured only at the 4th; starved stays 0 with STARVE_LIMIT=255.
- Starvation: STARVE_LIMIT=3, available=0 for 5 cycles then 1 → starved_output=1 from the cycle after the 3rd stall, then cleared once back in IDLE; the write commits correctly.
- Response backpressure: rsp_ready=0 for 4 cycles → rsp_valid and rsp_data stay stable, req_ready=0, CE=0; the response completes on rsp_ready=1.
- Reset mid-read: deassert rst_n during the 1st ACCESS cycle → the next cycle shows CE=0, rsp_valid=0, data_inout=Z; req_ready=1 after release; no stale response appears.
